// File: rtl/conv_ctrl_fsm_param_if.sv
// Host-stream and output-coordinate handshake bundle for conv_ctrl_fsm_param.
// The master modport is the controller side and the slave modport is the host/consumer side.
interface conv_ctrl_fsm_param_if;
    logic        con_valid;
    logic        con_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_x;
    logic [31:0] output_y;
    logic [31:0] output_ch;

    modport master (
        input  con_valid,
        input  out_ready,
        output con_ready,
        output out_valid,
        output output_x,
        output output_y,
        output output_ch
    );

    modport slave (
        output con_valid,
        output out_ready,
        input  con_ready,
        input  out_valid,
        input  output_x,
        input  output_y,
        input  output_ch
    );
endinterface

// File: rtl/conv_ctrl_fsm_param.sv
// Convolution loop-nest controller: group -> y -> x -> (input beats, then group_size outputs).
// Optional stall-cycle counter is built only when CTRL_FSM_STALL_CNT_EN is defined.
//
// state       | meaning
// S_IDLE      | waiting for start, all outputs quiet
// S_LOAD_K    | loading group_size kernels of KERNEL_WORDS words each
// S_PRE_I     | loading one preamble input column
// S_PRE_SHIFT | shifting a preloaded column into the window
// S_COMP      | loading the current column with MAC on every beat
// S_EMIT      | presenting group_size output coordinates
// S_ADV       | shifting the window and advancing x / y / group
module conv_ctrl_fsm_param #(
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int CH_GROUP           = 6,
    parameter int KERNEL_WORDS       = 12,
    parameter int INPUT_WORDS        = 4,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                                clk,
    input  logic                                arst_n_in,
    input  logic                                start,
    output logic                                running,
    conv_ctrl_fsm_param_if.master               bus,
    output logic [KERNEL_WORDS-1:0]             kds_le_sel,
    output logic [$clog2(CH_GROUP)-1:0]         kds_kernel_idx,
    output logic [$clog2(INPUT_WORDS+1)-1:0]    idss_le_sel,
    output logic                                idss_shift,
    output logic                                mac_enable,
    output logic [$clog2(CH_GROUP+1)-1:0]       group_size,
    output logic [31:0]                         stall_cycles
);

    localparam int KIDX_W = $clog2(CH_GROUP);
    localparam int GS_W   = $clog2(CH_GROUP + 1);
    localparam int KW_W   = (KERNEL_WORDS > 1) ? $clog2(KERNEL_WORDS) : 1;
    localparam int IW_W   = $clog2(INPUT_WORDS + 1);
    localparam int X_W    = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1;
    localparam int Y_W    = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int GB_W   = $clog2(OUTPUT_NB_CHANNELS + 1);
    localparam int PRE_W  = $clog2(KERNEL_SIZE);

    localparam logic [KW_W-1:0]  W_LAST   = KW_W'(KERNEL_WORDS - 1);
    localparam logic [IW_W-1:0]  IW_LAST  = IW_W'(INPUT_WORDS - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(KERNEL_SIZE - 2);
    localparam logic [31:0]      NB_32    = 32'(OUTPUT_NB_CHANNELS);
    localparam logic [31:0]      CG_32    = 32'(CH_GROUP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_PRE_I,
        S_PRE_SHIFT,
        S_COMP,
        S_EMIT,
        S_ADV
    } state_t;

    state_t            r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [GB_W-1:0]   r_group_base;
    logic [KW_W-1:0]   r_w;
    logic [KIDX_W-1:0] r_k;
    logic [IW_W-1:0]   r_iw;
    logic [PRE_W-1:0]  r_pre;
    logic [KIDX_W-1:0] r_e;

    logic [31:0]       w_remaining;
    logic [GS_W-1:0]   w_group_size;
    logic [KIDX_W-1:0] w_last_slot;
    logic [31:0]       w_gb_next;
    logic              w_con_ready;
    logic              w_out_valid;
    logic              w_in_load;

    // The last group may be partial: its size is whatever channels remain.
    assign w_remaining  = NB_32 - 32'(r_group_base);
    assign w_group_size = (w_remaining >= CG_32) ? GS_W'(CH_GROUP) : GS_W'(w_remaining);
    assign w_last_slot  = KIDX_W'(w_group_size - GS_W'(1));
    assign w_gb_next    = 32'(r_group_base) + 32'(w_group_size);

    assign w_con_ready  = (r_state == S_LOAD_K) || (r_state == S_PRE_I) || (r_state == S_COMP);
    assign w_out_valid  = (r_state == S_EMIT);
    assign w_in_load    = ((r_state == S_PRE_I) || (r_state == S_COMP)) && bus.con_valid;

    assign running        = (r_state != S_IDLE);
    assign bus.con_ready  = w_con_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.output_x   = 32'(r_x);
    assign bus.output_y   = 32'(r_y);
    assign bus.output_ch  = 32'(r_group_base) + 32'(r_e);
    assign kds_le_sel     = ((r_state == S_LOAD_K) && bus.con_valid) ?
                            (KERNEL_WORDS'(1) << r_w) : '0;
    assign kds_kernel_idx = r_k;
    assign idss_le_sel    = w_in_load ? (r_iw + IW_W'(1)) : '0;
    assign idss_shift     = (r_state == S_PRE_SHIFT) || (r_state == S_ADV);
    assign mac_enable     = (r_state == S_COMP) && bus.con_valid;
    assign group_size     = w_group_size;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_group_base <= '0;
            r_w          <= '0;
            r_k          <= '0;
            r_iw         <= '0;
            r_pre        <= '0;
            r_e          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x          <= '0;
                        r_y          <= '0;
                        r_group_base <= '0;
                        r_w          <= '0;
                        r_k          <= '0;
                        r_iw         <= '0;
                        r_pre        <= '0;
                        r_e          <= '0;
                        r_state      <= S_LOAD_K;
                    end
                end
                S_LOAD_K: begin
                    if (bus.con_valid) begin
                        if (r_w == W_LAST) begin
                            r_w <= '0;
                            if (r_k == w_last_slot) begin
                                r_k     <= '0;
                                r_state <= S_PRE_I;
                            end else begin
                                r_k <= r_k + KIDX_W'(1);
                            end
                        end else begin
                            r_w <= r_w + KW_W'(1);
                        end
                    end
                end
                S_PRE_I: begin
                    if (bus.con_valid) begin
                        if (r_iw == IW_LAST) begin
                            r_iw    <= '0;
                            r_state <= S_PRE_SHIFT;
                        end else begin
                            r_iw <= r_iw + IW_W'(1);
                        end
                    end
                end
                S_PRE_SHIFT: begin
                    if (r_pre == PRE_LAST) begin
                        r_pre   <= '0;
                        r_state <= S_COMP;
                    end else begin
                        r_pre   <= r_pre + PRE_W'(1);
                        r_state <= S_PRE_I;
                    end
                end
                S_COMP: begin
                    if (bus.con_valid) begin
                        if (r_iw == IW_LAST) begin
                            r_iw    <= '0;
                            r_e     <= '0;
                            r_state <= S_EMIT;
                        end else begin
                            r_iw <= r_iw + IW_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        if (r_e == w_last_slot) begin
                            r_e     <= '0;
                            r_state <= S_ADV;
                        end else begin
                            r_e <= r_e + KIDX_W'(1);
                        end
                    end
                end
                S_ADV: begin
                    // A new row needs the window refilled before MACs resume.
                    if (r_x != X_LAST) begin
                        r_x     <= r_x + X_W'(1);
                        r_state <= S_COMP;
                    end else if (r_y != Y_LAST) begin
                        r_x     <= '0;
                        r_y     <= r_y + Y_W'(1);
                        r_state <= S_PRE_I;
                    end else if (w_gb_next < NB_32) begin
                        r_x          <= '0;
                        r_y          <= '0;
                        r_group_base <= GB_W'(w_gb_next);
                        r_state      <= S_LOAD_K;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CTRL_FSM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (w_con_ready & ~bus.con_valid) | (w_out_valid & ~bus.out_ready);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_ctrl_fsm_param.sv
// Randomised self-checking bench for conv_ctrl_fsm_param against a loop-nest reference model.
module tb_conv_ctrl_fsm_param;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int NB  = 8;
    localparam int CG  = 3;
    localparam int KW  = 12;
    localparam int IW  = 4;
    localparam int KS  = 3;
    localparam int BUDGET = 5000;
`ifdef CTRL_FSM_STALL_CNT_EN
    localparam int HOLD_STALL = 10;
`else
    localparam int HOLD_STALL = 0;
`endif

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } out_t;

    typedef struct packed {
        logic [1:0]    idx;
        logic [KW-1:0] sel;
        logic [1:0]    gs;
    } kb_t;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start;
    logic        running;
    logic [KW-1:0] kds_le_sel;
    logic [1:0]  kds_kernel_idx;
    logic [2:0]  idss_le_sel;
    logic        idss_shift;
    logic        mac_enable;
    logic [1:0]  group_size;
    logic [31:0] stall_cycles;

    conv_ctrl_fsm_param_if bus_if ();

    conv_ctrl_fsm_param #(
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .OUTPUT_NB_CHANNELS(NB),
        .CH_GROUP          (CG),
        .KERNEL_WORDS      (KW),
        .INPUT_WORDS       (IW),
        .KERNEL_SIZE       (KS)
    ) dut (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .start         (start),
        .running       (running),
        .bus           (bus_if),
        .kds_le_sel    (kds_le_sel),
        .kds_kernel_idx(kds_kernel_idx),
        .idss_le_sel   (idss_le_sel),
        .idss_shift    (idss_shift),
        .mac_enable    (mac_enable),
        .group_size    (group_size),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    out_t exp_o[$];
    kb_t  exp_k[$];
    int   exp_i[$];
    int   exp_mac;
    int   exp_cycles;

    out_t obs_o[$];
    kb_t  obs_k[$];
    int   obs_i[$];
    int   n_mac, run_cycles, last_hs_cyc, drop_cyc;
    int   en_viol, onehot_viol, hold_viol, hold_cnt;
    bit   timed_out;

    // Reference: walk the loop nest directly, using the documented per-phase cycle costs.
    task automatic build_model();
        int gb, gs;
        logic [KW-1:0] one;
        one = 1;
        gb = 0;
        exp_mac = 0;
        exp_cycles = 0;
        while (gb < NB) begin
            gs = (NB - gb < CG) ? NB - gb : CG;
            exp_cycles += gs * KW;
            for (int k = 0; k < gs; k++)
                for (int w = 0; w < KW; w++)
                    exp_k.push_back('{idx: 2'(k), sel: one << w, gs: 2'(gs)});
            for (int y = 0; y < H; y++) begin
                exp_cycles += (KS - 1) * (IW + 1);
                for (int p = 0; p < KS - 1; p++)
                    for (int w = 0; w < IW; w++) exp_i.push_back(w + 1);
                for (int x = 0; x < W; x++) begin
                    for (int w = 0; w < IW; w++) begin
                        exp_i.push_back(w + 1);
                        exp_mac++;
                    end
                    for (int e = 0; e < gs; e++)
                        exp_o.push_back('{x: 32'(x), y: 32'(y), ch: 32'(gb + e)});
                    exp_cycles += IW + gs + 1;
                end
            end
            gb += gs;
        end
    endtask

    function automatic int count_out_bad();
        int bad;
        bad = (obs_o.size() > exp_o.size()) ? obs_o.size() - exp_o.size() : exp_o.size() - obs_o.size();
        for (int i = 0; i < obs_o.size() && i < exp_o.size(); i++)
            if (obs_o[i] !== exp_o[i]) bad++;
        return bad;
    endfunction

    function automatic int count_k_bad();
        int bad;
        bad = (obs_k.size() > exp_k.size()) ? obs_k.size() - exp_k.size() : exp_k.size() - obs_k.size();
        for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++)
            if (obs_k[i] !== exp_k[i]) bad++;
        return bad;
    endfunction

    function automatic int count_i_bad();
        int bad;
        bad = (obs_i.size() > exp_i.size()) ? obs_i.size() - exp_i.size() : exp_i.size() - obs_i.size();
        for (int i = 0; i < obs_i.size() && i < exp_i.size(); i++)
            if (obs_i[i] != exp_i[i]) bad++;
        return bad;
    endfunction

    // Drives one full layer and records what the controller did; v_mode 0=always,1=toggle,2=random;
    // r_mode 0=always, 2=random, 3=held low for the first 10 EMIT cycles.
    task automatic run_layer(input int v_mode, input int r_mode, input bit noise);
        int  cyc;
        bit  seen_ov, ov_s;
        logic [31:0] hold_ch;
        obs_o.delete(); obs_k.delete(); obs_i.delete();
        n_mac = 0; run_cycles = 0; last_hs_cyc = -100; drop_cyc = -1;
        en_viol = 0; onehot_viol = 0; hold_viol = 0; hold_cnt = 0;
        timed_out = 0; seen_ov = 0; ov_s = 0; hold_ch = '0;
        @(posedge clk); #1;
        start = 1'b1;
        bus_if.con_valid = (v_mode == 2) ? ($urandom_range(0, 99) < 60) : 1'b1;
        bus_if.out_ready = (r_mode == 3) ? 1'b0 : (r_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!running) begin
                drop_cyc = cyc;
                break;
            end
            run_cycles++;
            ov_s = bus_if.out_valid;
            if (kds_le_sel != '0) begin
                obs_k.push_back('{idx: kds_kernel_idx, sel: kds_le_sel, gs: group_size});
                if (!$onehot(kds_le_sel)) onehot_viol++;
            end
            if (!bus_if.con_valid && (kds_le_sel != '0 || idss_le_sel != '0 || mac_enable)) en_viol++;
            if (idss_le_sel != '0) obs_i.push_back(int'(idss_le_sel));
            if (mac_enable) n_mac++;
            if (bus_if.out_valid && bus_if.out_ready) begin
                obs_o.push_back('{x: bus_if.output_x, y: bus_if.output_y, ch: bus_if.output_ch});
                last_hs_cyc = cyc;
            end
            if (r_mode == 3 && hold_cnt < 10 && (seen_ov || bus_if.out_valid)) begin
                if (!seen_ov) hold_ch = bus_if.output_ch;
                seen_ov = 1;
                if (!bus_if.out_valid || bus_if.output_ch !== hold_ch) hold_viol++;
                hold_cnt++;
            end
            cyc++;
            if (cyc >= BUDGET) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            case (v_mode)
                0:       bus_if.con_valid = 1'b1;
                1:       bus_if.con_valid = ~bus_if.con_valid;
                default: bus_if.con_valid = ($urandom_range(0, 99) < 60);
            endcase
            case (r_mode)
                0:       bus_if.out_ready = 1'b1;
                3:       bus_if.out_ready = (hold_cnt >= 10);
                default: bus_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            start = noise && ov_s && ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        arst_n_in = 1'b0;
        start = 1'b0;
        bus_if.con_valid = 1'b0;
        bus_if.out_ready = 1'b0;
        #12;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0d want 0", running); end
        checks++; if (bus_if.con_ready !== 1'b0) begin errors++; $display("FAIL reset_con_ready: got %0d want 0", bus_if.con_ready); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d want 0", bus_if.out_valid); end
        checks++; if ({kds_le_sel, kds_kernel_idx, idss_le_sel, idss_shift, mac_enable} !== '0) begin
            errors++; $display("FAIL reset_enables: got %h want 0", {kds_le_sel, kds_kernel_idx, idss_le_sel, idss_shift, mac_enable}); end
        checks++; if ({bus_if.output_x, bus_if.output_y, bus_if.output_ch} !== '0) begin
            errors++; $display("FAIL reset_coords: got %h want 0", {bus_if.output_x, bus_if.output_y, bus_if.output_ch}); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        checks++; if (group_size !== 2'd3) begin errors++; $display("FAIL reset_group_size: got %0d want 3", group_size); end
        #10 arst_n_in = 1'b1;
        @(negedge clk);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %0d want 0", running); end
    endtask

    task automatic test_continuous();
        int n_last_k, n_last_o;
        run_layer(0, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL cont_timeout: got 1 want 0"); end
        checks++; if (obs_o.size() != 64) begin errors++; $display("FAIL cont_hs_count: got %0d want 64", obs_o.size()); end
        for (int i = 0; i < obs_o.size() && i < exp_o.size(); i++) begin
            checks++;
            if (obs_o[i] !== exp_o[i]) begin
                errors++;
                $display("FAIL cont_out[%0d]: got x%0d y%0d ch%0d want x%0d y%0d ch%0d", i,
                         obs_o[i].x, obs_o[i].y, obs_o[i].ch, exp_o[i].x, exp_o[i].y, exp_o[i].ch);
            end
        end
        checks++; if (obs_k.size() != 96) begin errors++; $display("FAIL cont_k_count: got %0d want 96", obs_k.size()); end
        for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++) begin
            checks++;
            if (obs_k[i] !== exp_k[i]) begin
                errors++;
                $display("FAIL cont_kbeat[%0d]: got %h want %h", i, obs_k[i], exp_k[i]);
            end
        end
        n_last_k = 0; n_last_o = 0;
        foreach (obs_k[i]) if (obs_k[i].gs == 2'd2) n_last_k++;
        foreach (obs_o[i]) if (obs_o[i].ch == 6 || obs_o[i].ch == 7) n_last_o++;
        checks++; if (n_last_k != 24) begin errors++; $display("FAIL last_group_kbeats: got %0d want 24", n_last_k); end
        checks++; if (n_last_o != 16) begin errors++; $display("FAIL last_group_outputs: got %0d want 16", n_last_o); end
        checks++; if (count_i_bad() != 0) begin errors++; $display("FAIL cont_idss: got %0d bad want 0", count_i_bad()); end
        checks++; if (n_mac != exp_mac) begin errors++; $display("FAIL cont_mac: got %0d want %0d", n_mac, exp_mac); end
        checks++; if (run_cycles != exp_cycles) begin errors++; $display("FAIL cont_cycles: got %0d want %0d", run_cycles, exp_cycles); end
        checks++; if (drop_cyc != last_hs_cyc + 2) begin errors++; $display("FAIL running_drop: got %0d want %0d", drop_cyc, last_hs_cyc + 2); end
        checks++; if (onehot_viol != 0 || en_viol != 0) begin errors++; $display("FAIL cont_enables: got %0d/%0d want 0/0", onehot_viol, en_viol); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL cont_stall: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_valid_toggle();
        int bad_idx;
        run_layer(1, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL tog_timeout: got 1 want 0"); end
        bad_idx = 0;
        for (int i = 0; i < 36 && i < obs_k.size(); i++) if (int'(obs_k[i].idx) != i / KW) bad_idx++;
        checks++; if (obs_k.size() < 36 || bad_idx != 0) begin
            errors++; $display("FAIL tog_first_group: got %0d beats %0d bad idx want 36+ beats 0 bad", obs_k.size(), bad_idx); end
        checks++; if (count_k_bad() != 0) begin errors++; $display("FAIL tog_kbeats: got %0d bad want 0", count_k_bad()); end
        checks++; if (onehot_viol != 0) begin errors++; $display("FAIL tog_onehot: got %0d want 0", onehot_viol); end
        checks++; if (en_viol != 0) begin errors++; $display("FAIL tog_idle_enables: got %0d want 0", en_viol); end
        checks++; if (count_out_bad() != 0) begin errors++; $display("FAIL tog_outputs: got %0d bad want 0", count_out_bad()); end
        checks++; if (count_i_bad() != 0) begin errors++; $display("FAIL tog_idss: got %0d bad want 0", count_i_bad()); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            run_layer(2, 2, 0);
            checks++; if (timed_out) begin errors++; $display("FAIL rnd_timeout: got 1 want 0"); end
            checks++; if (count_out_bad() != 0) begin errors++; $display("FAIL rnd_outputs: got %0d bad want 0", count_out_bad()); end
            checks++; if (count_k_bad() != 0) begin errors++; $display("FAIL rnd_kbeats: got %0d bad want 0", count_k_bad()); end
            checks++; if (count_i_bad() != 0) begin errors++; $display("FAIL rnd_idss: got %0d bad want 0", count_i_bad()); end
            checks++; if (n_mac != exp_mac) begin errors++; $display("FAIL rnd_mac: got %0d want %0d", n_mac, exp_mac); end
            checks++; if (en_viol != 0 || onehot_viol != 0) begin errors++; $display("FAIL rnd_enables: got %0d/%0d want 0/0", en_viol, onehot_viol); end
        end
    endtask

    task automatic test_backpressure();
        run_layer(0, 3, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got 1 want 0"); end
        checks++; if (hold_cnt != 10 || hold_viol != 0) begin
            errors++; $display("FAIL bp_hold: got %0d cycles %0d unstable want 10 cycles 0 unstable", hold_cnt, hold_viol); end
        checks++; if (count_out_bad() != 0) begin errors++; $display("FAIL bp_outputs: got %0d bad want 0", count_out_bad()); end
        checks++; if (stall_cycles !== 32'(HOLD_STALL)) begin errors++; $display("FAIL bp_stall: got %0d want %0d", stall_cycles, HOLD_STALL); end
    endtask

    task automatic test_start_ignored();
        run_layer(2, 2, 1);
        checks++; if (timed_out) begin errors++; $display("FAIL noise_timeout: got 1 want 0"); end
        checks++; if (count_out_bad() != 0) begin errors++; $display("FAIL noise_outputs: got %0d bad want 0", count_out_bad()); end
        checks++; if (count_k_bad() != 0) begin errors++; $display("FAIL noise_kbeats: got %0d bad want 0", count_k_bad()); end
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  found;
        @(posedge clk); #1;
        start = 1'b1;
        bus_if.con_valid = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (mac_enable && obs_o.size() >= 0 && n > 150) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_comp: got 0 want 1"); end
        #1 arst_n_in = 1'b0;
        #1;
        checks++; if ({running, bus_if.con_ready, bus_if.out_valid, idss_shift, mac_enable} !== '0) begin
            errors++; $display("FAIL rstmid_ctrl: got %b want 0", {running, bus_if.con_ready, bus_if.out_valid, idss_shift, mac_enable}); end
        checks++; if ({kds_le_sel, kds_kernel_idx, idss_le_sel, stall_cycles} !== '0) begin
            errors++; $display("FAIL rstmid_sel: got %h want 0", {kds_le_sel, kds_kernel_idx, idss_le_sel, stall_cycles}); end
        checks++; if ({bus_if.output_x, bus_if.output_y, bus_if.output_ch} !== '0) begin
            errors++; $display("FAIL rstmid_coords: got %h want 0", {bus_if.output_x, bus_if.output_y, bus_if.output_ch}); end
        #10 arst_n_in = 1'b1;
        @(negedge clk);
        checks++; if (running !== 1'b0 || bus_if.con_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got %0d%0d want 00", running, bus_if.con_ready); end
        run_layer(0, 0, 0);
        checks++; if (obs_o.size() == 0 || obs_o[0] !== exp_o[0]) begin
            errors++; $display("FAIL rstmid_replay_first: got %0d outputs want first x0 y0 ch0", obs_o.size()); end
        checks++; if (count_out_bad() != 0) begin errors++; $display("FAIL rstmid_replay: got %0d bad want 0", count_out_bad()); end
    endtask

    initial begin
        build_model();
        test_reset();
        test_continuous();
        test_valid_toggle();
        test_random();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
